reg_bank_rw: RTL
================

// Module: reg_bank_rw
// PURPOSE
//   Parametrised bank of NUM_REGS bus-writable registers for the pointcloud datapath.
//   Successor to the single read/write register.
//   Adds per-register clear, increment and decrement for address/counter use.
//   Adds sticky wrap flags, zero flags and a registered read port with an optional write-through mode.
//   Sits between the shared data bus (BusOut) and the control unit, which drives WEN/WSEL/INC/DEC/CLR.
// PARAMETERS
//   WIDTH          8    data width of each register and of BusOut/dout
//   NUM_REGS       4    number of registers (>=2)
//   SEL_W          2    select width, = $clog2(NUM_REGS)
//   WRITE_THROUGH  0    1: a same-cycle write to the RSEL register is forwarded to dout
//   RESET_VAL      0    value loaded into every register on RST
// PORTS
//   Clk     in   1          clock, all state updates on posedge
//   RST     in   1          synchronous, active-high reset
//   BusOut  in   WIDTH      write data from the shared bus
//   WEN     in   1          write enable for register WSEL
//   WSEL    in   SEL_W      write register select
//   INC     in   NUM_REGS   per-register increment strobe
//   DEC     in   NUM_REGS   per-register decrement strobe
//   CLR     in   NUM_REGS   per-register clear-to-zero strobe
//   RSEL    in   SEL_W      read register select
//   dout    out  WIDTH      registered read data
//   Z       out  NUM_REGS   zero flag, combinational from stored value (reg==0)
//   WRAP    out  NUM_REGS   sticky overflow/underflow flag per register
// BEHAVIOUR
//   - Reset: RST=1 at posedge puts every register to RESET_VAL, dout to 0 and WRAP to 0.
//     Z follows the stored value (all 1 when RESET_VAL=0).
//     RST overrides every other input in the same cycle, including mid-sequence strobes.
//   - Per-register priority at each posedge, register i:
//     CLR[i] > (WEN && WSEL==i) > INC[i]^DEC[i].
//     If INC[i] and DEC[i] are both set, the register holds.
//   - Write: reg[WSEL] <= BusOut.
//     WSEL >= NUM_REGS changes no register and does not disturb other registers' INC/DEC/CLR.
//   - INC: reg <= reg+1, modulo 2^WIDTH. Going from all-ones to 0 sets WRAP[i].
//   - DEC: reg <= reg-1, modulo 2^WIDTH. Going from 0 to all-ones sets WRAP[i].
//   - WRAP[i] clears on CLR[i] or on a write to register i.
//     Set and clear in the same cycle cannot happen, because the priority rules make them exclusive.
//   - Independent registers update concurrently.
//     Example: write reg0 while INC reg1 and DEC reg3 in one cycle.
//   - Read, WRITE_THROUGH=0: dout <= reg[RSEL] as stored before this edge (1-cycle latency).
//     A write lands in dout one cycle after it completes.
//   - Read, WRITE_THROUGH=1: dout <= BusOut when WEN && WSEL==RSEL && !CLR[RSEL].
//     Otherwise dout behaves as in WRITE_THROUGH=0.
//   - RSEL >= NUM_REGS: dout <= 0.
//   - No X propagation: every output has a defined value from the first RST cycle on.
// STRUCTURE
//   - Shared package/include (reg_bank_defs.vh):
//     - register index constants (e.g. REG_ADDR_SRC, REG_ADDR_DST, REG_CNT_X, REG_CNT_Y)
//     - default WIDTH/NUM_REGS used by the pointcloud top level
//   - Sub-module reg_cell_rw holds one register.
//     - inputs: Clk, RST, ld, ld_data, clr, inc, dec
//     - outputs: q, z, wrap
//     - implements the priority, wrap and sticky-flag logic
//   - reg_bank_rw instantiates NUM_REGS reg_cell_rw via generate.
//     It also holds the WSEL decode, the read mux and the dout register.
// TESTING  (WIDTH=8, NUM_REGS=4 unless stated)
//   1. Reset: RST=1 for 2 cycles with random strobes.
//      -> all regs 0, dout=8'h00, Z=4'b1111, WRAP=4'b0000.
//   2. Write/read: WEN=1, WSEL=2, BusOut=8'hAA, RSEL=2.
//      -> WRITE_THROUGH=0: dout=8'hAA on the second edge.
//      -> WRITE_THROUGH=1: dout=8'hAA on the first edge.
//   3. Wrap: write reg1=8'hFE, then INC[1] for 2 cycles.
//      -> reg1 8'hFF then 8'h00, WRAP[1]=1, Z[1]=1.
//      -> DEC[1] gives 8'hFF with WRAP[1] still 1; a write to reg1 clears WRAP[1].
//   4. Collisions: WEN to reg0 (BusOut=8'h10) with INC[0]=1 -> reg0=8'h10.
//      -> INC[3]=DEC[3]=1 -> reg3 holds.
//      -> CLR[0] with WEN to reg0 -> reg0=0.
//   5. Mid-operation reset: reg2=8'h55 and WEN/INC active, then RST=1 for one cycle.
//      -> every reg 0, dout 0, WRAP 0 on that edge; normal operation resumes next cycle.
//   6. Out of range (NUM_REGS=3, SEL_W=2): WEN with WSEL=3 -> no register changes; RSEL=3 -> dout=0.

Source files
------------

// File: rtl/reg_bank_rw_pkg.sv
// Shared constants and per-cell operation decode for the pointcloud register bank.
// Index constants name the registers as the pointcloud top level wires them.
package reg_bank_rw_pkg;

    localparam int DEF_WIDTH    = 8;
    localparam int DEF_NUM_REGS = 4;

    localparam int REG_ADDR_SRC = 0;
    localparam int REG_ADDR_DST = 1;
    localparam int REG_CNT_X    = 2;
    localparam int REG_CNT_Y    = 3;

    typedef enum logic [2:0] {
        OP_HOLD,
        OP_CLR,
        OP_LD,
        OP_INC,
        OP_DEC
    } cell_op_e;

    // Clear beats load beats count; opposing count strobes cancel.
    function automatic cell_op_e op_sel(input logic clr, input logic ld,
                                        input logic inc, input logic dec);
        cell_op_e op;
        op = OP_HOLD;
        if (clr)             op = OP_CLR;
        else if (ld)         op = OP_LD;
        else if (inc && !dec) op = OP_INC;
        else if (dec && !inc) op = OP_DEC;
        return op;
    endfunction

endpackage

// File: rtl/reg_cell_rw.sv
// One bank register: clear / load / increment / decrement with a sticky wrap flag.
// The zero flag is taken straight from the stored value.
module reg_cell_rw
    import reg_bank_rw_pkg::*;
#(
    parameter int               WIDTH     = DEF_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             Clk,
    input  logic             RST,
    input  logic             ld,
    input  logic [WIDTH-1:0] ld_data,
    input  logic             clr,
    input  logic             inc,
    input  logic             dec,
    output logic [WIDTH-1:0] q,
    output logic             z,
    output logic             wrap
);

    logic [WIDTH-1:0] r_q;
    logic             r_wrap;
    cell_op_e         w_op;

    always_comb begin
        w_op = op_sel(clr, ld, inc, dec);
    end

    always_ff @(posedge Clk) begin
        if (RST) begin
            r_q    <= RESET_VAL;
            r_wrap <= 1'b0;
        end else begin
            case (w_op)
                OP_CLR: begin
                    r_q    <= '0;
                    r_wrap <= 1'b0;
                end
                OP_LD: begin
                    r_q    <= ld_data;
                    r_wrap <= 1'b0;
                end
                OP_INC: begin
                    r_q <= r_q + WIDTH'(1);
                    if (r_q == '1) r_wrap <= 1'b1;
                end
                OP_DEC: begin
                    r_q <= r_q - WIDTH'(1);
                    if (r_q == '0) r_wrap <= 1'b1;
                end
                default: begin
                    r_q    <= r_q;
                    r_wrap <= r_wrap;
                end
            endcase
        end
    end

    assign q    = r_q;
    assign z    = (r_q == '0);
    assign wrap = r_wrap;

endmodule

// File: rtl/reg_bank_rw.sv
// Bank of NUM_REGS reg_cell_rw registers with write decode and a registered read port.
// WRITE_THROUGH=1 forwards a same-cycle write of the read register straight to dout.
module reg_bank_rw
    import reg_bank_rw_pkg::*;
#(
    parameter int               WIDTH         = DEF_WIDTH,
    parameter int               NUM_REGS      = DEF_NUM_REGS,
    parameter int               SEL_W         = $clog2(NUM_REGS),
    parameter bit               WRITE_THROUGH = 1'b0,
    parameter logic [WIDTH-1:0] RESET_VAL     = '0
) (
    input  logic                Clk,
    input  logic                RST,
    input  logic [WIDTH-1:0]    BusOut,
    input  logic                WEN,
    input  logic [SEL_W-1:0]    WSEL,
    input  logic [NUM_REGS-1:0] INC,
    input  logic [NUM_REGS-1:0] DEC,
    input  logic [NUM_REGS-1:0] CLR,
    input  logic [SEL_W-1:0]    RSEL,
    output logic [WIDTH-1:0]    dout,
    output logic [NUM_REGS-1:0] Z,
    output logic [NUM_REGS-1:0] WRAP
);

    logic [NUM_REGS-1:0]            w_ld;
    logic [NUM_REGS-1:0][WIDTH-1:0] w_q;
    logic [WIDTH-1:0]               w_rd;
    logic [WIDTH-1:0]               r_dout;

    // Selects beyond NUM_REGS match no cell, so they load nothing and read 0.
    always_comb begin
        w_ld = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            w_ld[i] = WEN && (WSEL == SEL_W'(i));
        end
    end

    always_comb begin
        w_rd = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (RSEL == SEL_W'(i)) begin
                if (WRITE_THROUGH && w_ld[i] && !CLR[i]) w_rd = BusOut;
                else                                      w_rd = w_q[i];
            end
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_cell
        reg_cell_rw #(
            .WIDTH     (WIDTH),
            .RESET_VAL (RESET_VAL)
        ) u_cell (
            .Clk     (Clk),
            .RST     (RST),
            .ld      (w_ld[g]),
            .ld_data (BusOut),
            .clr     (CLR[g]),
            .inc     (INC[g]),
            .dec     (DEC[g]),
            .q       (w_q[g]),
            .z       (Z[g]),
            .wrap    (WRAP[g])
        );
    end

    always_ff @(posedge Clk) begin
        if (RST) r_dout <= '0;
        else     r_dout <= w_rd;
    end

    assign dout = r_dout;

endmodule
